// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step sequencer for the 4-bit SAP CPU: gates the datapath clock-enable,
// stops only at instruction boundaries, and counts retired instructions.
module cpu_run_ctrl #(
  parameter int unsigned CNT_W    = 16,
  parameter bit          AUTO_RUN = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_req,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic             hlt_op,
  input  logic             bp_en,
  input  logic [3:0]       bp_addr,
  input  logic [3:0]       pc,
  input  logic [1:0]       t_state,
  output logic             cpu_en,
  output logic             halted,
  output logic [1:0]       run_state,
  output logic             step_done,
  output logic             bp_hit,
  output logic             hlt_hit,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    S_HALTED = 2'b00,
    S_RUN    = 2'b01,
    S_STEP   = 2'b10,
    S_DRAIN  = 2'b11
  } state_e;

  localparam state_e RESET_STATE = AUTO_RUN ? S_RUN : S_HALTED;

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_step_done;
  logic             r_bp_hit;
  logic             r_hlt_hit;
  logic [CNT_W-1:0] r_retired;

  logic w_bnd;
  logic w_bp_c;
  logic w_stop_c;
  logic w_clr_flags;
  logic w_set_flags;
  logic w_step_done_nxt;

  assign cpu_en    = (r_state != S_HALTED);
  assign halted    = (r_state == S_HALTED);
  assign run_state = r_state;
  assign step_done = r_step_done;
  assign bp_hit    = r_bp_hit;
  assign hlt_hit   = r_hlt_hit;
  assign retired   = r_retired;

  // The T-counter only moves while enabled, so T3 with cpu_en is the retiring edge.
  assign w_bnd    = cpu_en && (t_state == 2'b11);
  assign w_bp_c   = bp_en && (pc == bp_addr);
  assign w_stop_c = hlt_op || w_bp_c;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_state_nxt     = r_state;
    w_clr_flags     = 1'b0;
    w_set_flags     = 1'b0;
    w_step_done_nxt = 1'b0;
    case (r_state)
      S_HALTED: begin
        if (!halt_req) begin
          if (step_req) begin
            w_state_nxt = S_STEP;
            w_clr_flags = 1'b1;
          end else if (run_req) begin
            w_state_nxt = S_RUN;
            w_clr_flags = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (w_bnd && (w_stop_c || halt_req)) begin
          w_state_nxt = S_HALTED;
          w_set_flags = 1'b1;
        end else if (halt_req) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_bnd) begin
          w_state_nxt = S_HALTED;
          w_set_flags = 1'b1;
        end
      end
      S_STEP: begin
        if (w_bnd) begin
          w_state_nxt     = S_HALTED;
          w_set_flags     = 1'b1;
          w_step_done_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_HALTED;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= RESET_STATE;
      r_step_done <= 1'b0;
      r_bp_hit    <= 1'b0;
      r_hlt_hit   <= 1'b0;
      r_retired   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_step_done <= w_step_done_nxt;
      if (w_bnd) begin
        r_retired <= r_retired + CNT_W'(1);
      end
      // Flags are cleared on resume, so OR-ing at the stop records exactly this stop's causes.
      if (w_clr_flags) begin
        r_bp_hit  <= 1'b0;
        r_hlt_hit <= 1'b0;
      end else if (w_set_flags) begin
        r_bp_hit  <= r_bp_hit  | w_bp_c;
        r_hlt_hit <= r_hlt_hit | hlt_op;
      end
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: a small SAP CPU environment plus a behavioural
// run-control model compared every cycle, with directed scenarios and random requests.
module tb_cpu_run_ctrl;

  localparam int CNT_W = 16;

  logic             clk      = 1'b0;
  logic             rst      = 1'b0;
  logic             rst2     = 1'b0;
  logic             run_req  = 1'b0;
  logic             halt_req = 1'b0;
  logic             step_req = 1'b0;
  logic             hlt_op   = 1'b0;
  logic             bp_en    = 1'b0;
  logic [3:0]       bp_addr  = 4'h0;
  logic [3:0]       pc       = 4'h0;
  logic [1:0]       t_state  = 2'b00;
  logic             cpu_en;
  logic             halted;
  logic [1:0]       run_state;
  logic             step_done;
  logic             bp_hit;
  logic             hlt_hit;
  logic [CNT_W-1:0] retired;

  // Second instance: narrow counter, auto-run, no requests.
  logic       zero1    = 1'b0;
  logic [3:0] zero4    = 4'h0;
  logic [1:0] t_state2 = 2'b00;
  logic       cpu_en2;
  logic       halted2;
  logic [1:0] run_state2;
  logic       step_done2;
  logic       bp_hit2;
  logic       hlt_hit2;
  logic [3:0] retired2;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: is the CPU enabled, is it a single step, is a stop pending.
  bit               m_active, m_single, m_drain, m_sd, m_bp, m_hlt;
  logic [CNT_W-1:0] m_ret;
  // CPU environment: T-counter, PC, address of the instruction in IR, HLT placement.
  int               e_t;
  logic [3:0]       e_pc, e_ir, hlt_addr;
  bit               allow_jump, hlt_en;

  cpu_run_ctrl #(.CNT_W(CNT_W), .AUTO_RUN(1'b0)) u_dut (
    .clk(clk), .rst(rst), .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
    .hlt_op(hlt_op), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .t_state(t_state),
    .cpu_en(cpu_en), .halted(halted), .run_state(run_state), .step_done(step_done),
    .bp_hit(bp_hit), .hlt_hit(hlt_hit), .retired(retired)
  );

  cpu_run_ctrl #(.CNT_W(4), .AUTO_RUN(1'b1)) u_dut2 (
    .clk(clk), .rst(rst2), .run_req(zero1), .halt_req(zero1), .step_req(zero1),
    .hlt_op(zero1), .bp_en(zero1), .bp_addr(zero4), .pc(zero4), .t_state(t_state2),
    .cpu_en(cpu_en2), .halted(halted2), .run_state(run_state2), .step_done(step_done2),
    .bp_hit(bp_hit2), .hlt_hit(hlt_hit2), .retired(retired2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_single = 1'b0; m_drain = 1'b0;
    m_sd = 1'b0; m_bp = 1'b0; m_hlt = 1'b0; m_ret = '0;
  endtask

  task automatic env_reset();
    e_t = 0; e_pc = 4'h0; e_ir = 4'h0;
  endtask

  task automatic apply_env();
    t_state = 2'(e_t);
    pc      = e_pc;
    hlt_op  = hlt_en && (e_ir == hlt_addr);
  endtask

  // One rising edge of the system, from the inputs the DUT is sampling.
  task automatic model_edge();
    bit en, bnd, hc, bc;
    en  = m_active;
    bnd = en && (e_t == 3);
    hc  = hlt_op;
    bc  = bp_en && (pc == bp_addr);
    m_sd = 1'b0;
    if (bnd) m_ret = m_ret + 1'b1;
    if (!en) begin
      if (!halt_req && (step_req || run_req)) begin
        m_active = 1'b1; m_single = step_req; m_drain = 1'b0;
        m_bp = 1'b0; m_hlt = 1'b0;
      end
    end else if (bnd && (m_single || m_drain || hc || bc || halt_req)) begin
      m_sd = m_single;
      m_active = 1'b0; m_single = 1'b0; m_drain = 1'b0;
      m_hlt = m_hlt | hc;
      m_bp  = m_bp | bc;
    end else if (!m_single && halt_req) begin
      m_drain = 1'b1;
    end
    if (en) begin
      if (e_t == 2) e_pc = (allow_jump && $urandom_range(3) == 0) ? 4'($urandom_range(15)) : e_pc + 4'h1;
      if (e_t == 3) e_ir = e_pc;
      e_t = (e_t + 1) % 4;
    end
  endtask

  task automatic compare();
    logic [1:0] exp_state;
    exp_state = !m_active ? 2'b00 : m_single ? 2'b10 : m_drain ? 2'b11 : 2'b01;
    check("cpu_en",    cpu_en,    m_active);
    check("halted",    halted,    !m_active);
    check("run_state", run_state, exp_state);
    check("step_done", step_done, m_sd);
    check("bp_hit",    bp_hit,    m_bp);
    check("hlt_hit",   hlt_hit,   m_hlt);
    check("retired",   retired,   m_ret);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
    apply_env();
  endtask

  task automatic pulse_run();
    run_req = 1'b1; tick(); run_req = 1'b0;
  endtask

  task automatic do_reset();
    #1 rst = 1'b0;
    run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;
    model_reset(); env_reset(); apply_env();
    #1 compare();
    @(negedge clk);
    rst = 1'b1;
    compare();
  endtask

  task automatic wait_halted(input int bound, input string name);
    int n = 0;
    while (halted !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    check(name, halted, 1'b1);
  endtask

  initial begin
    int n;
    int t2;
    allow_jump = 1'b0; hlt_en = 1'b0; hlt_addr = 4'h0;
    model_reset(); env_reset(); apply_env();
    #1 compare();
    check("reset_halted", halted, 1'b1);
    check("reset_cpu_en", cpu_en, 1'b0);
    check("reset_retired", retired, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Start running: enabled on the next cycle, three instructions in twelve cycles.
    pulse_run();
    check("run_cpu_en", cpu_en, 1'b1);
    repeat (12) tick();
    check("run_retired_3", retired, 3);

    // Halt request mid-instruction drains to the boundary.
    n = 0;
    while (e_t != 1 && n < 8) begin tick(); n++; end
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    check("drain_state", run_state, 2'b11);
    wait_halted(8, "drain_to_halt");
    check("drain_retired", retired, 4);
    check("drain_bp_hit", bp_hit, 1'b0);
    check("drain_hlt_hit", hlt_hit, 1'b0);

    // Single steps: four enabled cycles and one step_done pulse each.
    for (int k = 0; k < 3; k++) begin
      int en_n, sd_n;
      step_req = 1'b1; tick(); step_req = 1'b0;
      en_n = int'(cpu_en); sd_n = 0;
      repeat (6) begin
        tick();
        en_n += int'(cpu_en);
        sd_n += int'(step_done);
      end
      check("step_en_cycles", en_n, 4);
      check("step_done_pulses", sd_n, 1);
      check("step_halted", halted, 1'b1);
    end
    check("step_retired", retired, 7);

    // Breakpoint on pc 5: stops after instruction 4, resume executes instruction 5.
    do_reset();
    bp_en = 1'b1; bp_addr = 4'h5;
    pulse_run();
    wait_halted(40, "bp_stop");
    check("bp_retired", retired, 5);
    check("bp_hit_set", bp_hit, 1'b1);
    check("bp_hlt_clear", hlt_hit, 1'b0);
    pulse_run();
    check("bp_hit_cleared", bp_hit, 1'b0);
    repeat (4) tick();
    check("bp_resume_retired", retired, 6);
    check("bp_resume_running", cpu_en, 1'b1);
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    wait_halted(8, "bp_halt");
    bp_en = 1'b0;

    // HLT at 3 together with a breakpoint on 4: both causes recorded.
    do_reset();
    hlt_en = 1'b1; hlt_addr = 4'h3; bp_en = 1'b1; bp_addr = 4'h4;
    apply_env();
    pulse_run();
    wait_halted(40, "hlt_stop");
    check("hlt_hit_set", hlt_hit, 1'b1);
    check("hlt_bp_hit_set", bp_hit, 1'b1);
    check("hlt_retired", retired, 4);
    hlt_en = 1'b0; bp_en = 1'b0;
    apply_env();

    // Asynchronous reset in the middle of T2.
    pulse_run();
    n = 0;
    while (e_t != 2 && n < 8) begin tick(); n++; end
    #2 rst = 1'b0;
    model_reset(); env_reset(); apply_env();
    #1 compare();
    check("midrst_halted", halted, 1'b1);
    check("midrst_retired", retired, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) tick();
    check("midrst_no_step_done", step_done, 1'b0);
    check("midrst_retired_after", retired, 0);

    // All three requests at once while halted: halt wins.
    halt_req = 1'b1; run_req = 1'b1; step_req = 1'b1;
    tick();
    halt_req = 1'b0; run_req = 1'b0; step_req = 1'b0;
    check("all_req_halted", halted, 1'b1);
    check("all_req_state", run_state, 2'b00);

    // Random requests, breakpoints, HLT placement and jumps.
    allow_jump = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) do_reset();
      run_req  = ($urandom_range(7) == 0);
      halt_req = ($urandom_range(11) == 0);
      step_req = ($urandom_range(7) == 0);
      if ($urandom_range(31) == 0) begin
        bp_en   = 1'($urandom_range(1));
        bp_addr = 4'($urandom_range(15));
      end
      if ($urandom_range(31) == 0) begin
        hlt_en   = 1'($urandom_range(1));
        hlt_addr = 4'($urandom_range(15));
      end
      apply_env();
      tick();
    end
    run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;
    tick();

    // Auto-run instance with a 4-bit counter: wraps after 16 instructions.
    rst2 = 1'b1;
    t2 = 0; t_state2 = 2'b00;
    #1;
    check("auto_state", run_state2, 2'b01);
    check("auto_cpu_en", cpu_en2, 1'b1);
    check("auto_halted", halted2, 1'b0);
    check("auto_retired0", retired2, 0);
    for (int e = 1; e <= 68; e++) begin
      @(posedge clk);
      @(negedge clk);
      t2 = (t2 + 1) % 4;
      t_state2 = 2'(t2);
      if (e == 60) check("auto_retired15", retired2, 4'hF);
      if (e == 64) check("auto_wrap0", retired2, 4'h0);
      if (e == 68) check("auto_wrap1", retired2, 4'h1);
    end
    check("auto_still_run", run_state2, 2'b01);
    check("auto_step_done", step_done2, 1'b0);
    check("auto_flags", {bp_hit2, hlt_hit2}, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
